// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-side signal bundle for the hazard/interlock unit
interface hazard_unit_if;
  // Decode-stage operands and instruction class
  logic [4:0]  rsD;
  logic [4:0]  rtD;
  logic        branchD;
  logic        mfhiloD;
  logic        mdstartD;
  // Execute / Memory destination info
  logic [4:0]  writeregE;
  logic [4:0]  writeregM;
  logic        regwriteE;
  logic        memtoregE;
  logic        memtoregM;
  logic        mdstartE;
  logic        mddivE;
  // Interlock and sequencer results
  logic        stallF;
  logic        stallD;
  logic        flushE;
  logic        mdbusy;
  logic        mddone;
  logic        mderr;
  logic [31:0] stallcnt;

  // Pipeline side: drives stage info, receives interlocks
  modport master (
    output rsD, rtD, branchD, mfhiloD, mdstartD,
    output writeregE, writeregM, regwriteE, memtoregE, memtoregM, mdstartE, mddivE,
    input  stallF, stallD, flushE, mdbusy, mddone, mderr, stallcnt
  );

  // Hazard unit side
  modport slave (
    input  rsD, rtD, branchD, mfhiloD, mdstartD,
    input  writeregE, writeregM, regwriteE, memtoregE, memtoregM, mdstartE, mddivE,
    output stallF, stallD, flushE, mdbusy, mddone, mderr, stallcnt
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush interlock and MULT/DIV busy sequencer; HAZARD_PERF_CNT_EN enables the stall-cycle counter
module hazard_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_unit_if.slave  hif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Counter reload values: the launch cycle's edge already consumes one busy cycle
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mderr_q, mderr_d;
  logic             mddone;

  logic             e_hit;
  logic             m_hit;
  logic             lwstall;
  logic             branchstall;
  logic             mdstall;
  logic             stall;

  // Source-register matches against E and M destinations; $0 never matches
  always_comb begin
    e_hit = (hif.writeregE != 5'd0) &&
            ((hif.writeregE == hif.rsD) || (hif.writeregE == hif.rtD));
    m_hit = (hif.writeregM != 5'd0) &&
            ((hif.writeregM == hif.rsD) || (hif.writeregM == hif.rtD));
  end

  // Hazard classes that bypassing cannot cover, combined into one interlock
  always_comb begin
    lwstall     = hif.memtoregE && e_hit;
    branchstall = hif.branchD &&
                  ((hif.regwriteE && e_hit) || (hif.memtoregM && m_hit));
    mdstall     = (hif.mfhiloD || hif.mdstartD) &&
                  ((state_q == S_BUSY) || hif.mdstartE);
    stall       = lwstall || branchstall || mdstall;
  end

  assign hif.stallF = stall;
  assign hif.stallD = stall;
  assign hif.flushE = stall;

  // Sequencer next state: a start arriving while busy (including the done cycle) is dropped and flagged
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mderr_d = mderr_q;
    mddone  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hif.mdstartE) begin
          cnt_d   = hif.mddivE ? DIV_LOAD : MUL_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (hif.mdstartE) begin
          mderr_d = 1'b1;
        end
        if (cnt_q == '0) begin
          mddone  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mderr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mderr_q <= mderr_d;
    end
  end

  assign hif.mdbusy = (state_q == S_BUSY);
  assign hif.mddone = mddone;
  assign hif.mderr  = mderr_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallcnt_q, stallcnt_d;

  // Count stalled cycles, holding at all-ones rather than wrapping
  always_comb begin
    stallcnt_d = stallcnt_q;
    if (stall && (stallcnt_q != 32'hFFFF_FFFF)) begin
      stallcnt_d = stallcnt_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallcnt_q <= 32'd0;
    end else begin
      stallcnt_q <= stallcnt_d;
    end
  end

  assign hif.stallcnt = stallcnt_q;
`else
  assign hif.stallcnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit (interlocks, sequencer, optional HAZARD_PERF_CNT_EN counter)
module tb_hazard_unit;

  typedef struct {
    string       name;
    logic        stall;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  exp_t        sb_q[$];
  int          errors;
  int          checks;
  logic [31:0] exp_cnt;

  hazard_unit_if hif ();

  hazard_unit #(
    .MUL_LAT (4),
    .DIV_LAT (32),
    .CNT_W   (6)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hif     (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s/%s: got %0h, expected %0h", name, field, got, want);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, "stallF",   {31'd0, hif.stallF}, {31'd0, e.stall});
      chk(e.name, "stallD",   {31'd0, hif.stallD}, {31'd0, e.stall});
      chk(e.name, "flushE",   {31'd0, hif.flushE}, {31'd0, e.stall});
      chk(e.name, "mdbusy",   {31'd0, hif.mdbusy}, {31'd0, e.busy});
      chk(e.name, "mddone",   {31'd0, hif.mddone}, {31'd0, e.done});
      chk(e.name, "mderr",    {31'd0, hif.mderr},  {31'd0, e.err});
      chk(e.name, "stallcnt", hif.stallcnt,         e.cnt);
    end
  end

  task automatic clr();
    hif.rsD = 5'd0;       hif.rtD = 5'd0;
    hif.branchD = 1'b0;   hif.mfhiloD = 1'b0;   hif.mdstartD = 1'b0;
    hif.writeregE = 5'd0; hif.writeregM = 5'd0;
    hif.regwriteE = 1'b0; hif.memtoregE = 1'b0; hif.memtoregM = 1'b0;
    hif.mdstartE = 1'b0;  hif.mddivE = 1'b0;
  endtask

  // Issue the current inputs for one cycle with their hand-computed response
  task automatic vec(input string name, input bit st, input bit bz,
                     input bit dn, input bit er);
    exp_t e;
    if (!reset_n) exp_cnt = 32'd0;
    e.name  = name;
    e.stall = st;
    e.busy  = bz;
    e.done  = dn;
    e.err   = er;
    e.cnt   = exp_cnt;
    sb_q.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
    if (reset_n && st && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 32'd0;
    reset_n = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // Reset state
    vec("reset0", 0, 0, 0, 0);
    vec("reset1", 0, 0, 0, 0);
    reset_n = 1'b1;
    vec("idle", 0, 0, 0, 0);

    // Load-use
    clr(); hif.memtoregE = 1; hif.writeregE = 5'd8; hif.rsD = 5'd8;
    vec("lw_rs", 1, 0, 0, 0);
    clr(); hif.memtoregE = 1; hif.writeregE = 5'd8; hif.rtD = 5'd8;
    vec("lw_rt", 1, 0, 0, 0);
    clr(); hif.memtoregE = 1; hif.writeregE = 5'd0; hif.rsD = 5'd0;
    vec("lw_r0", 0, 0, 0, 0);
    clr(); hif.memtoregE = 1; hif.writeregE = 5'd8; hif.rsD = 5'd9; hif.rtD = 5'd10;
    vec("lw_nomatch", 0, 0, 0, 0);
    clr(); hif.regwriteE = 1; hif.writeregE = 5'd8; hif.rsD = 5'd8;
    vec("alu_fwd", 0, 0, 0, 0);

    // Branch compare in Decode
    clr(); hif.branchD = 1; hif.rtD = 5'd9; hif.regwriteE = 1; hif.writeregE = 5'd9;
    vec("br_e", 1, 0, 0, 0);
    clr(); hif.branchD = 1; hif.rtD = 5'd9; hif.memtoregM = 1; hif.writeregM = 5'd9;
    vec("br_m", 1, 0, 0, 0);
    clr(); hif.branchD = 1; hif.rtD = 5'd9; hif.regwriteE = 1; hif.writeregE = 5'd10;
    vec("br_nomatch", 0, 0, 0, 0);
    clr(); hif.branchD = 1; hif.memtoregM = 1; hif.writeregM = 5'd0;
    vec("br_m_r0", 0, 0, 0, 0);
    clr(); hif.branchD = 1; hif.rsD = 5'd12; hif.regwriteE = 1; hif.writeregE = 5'd12;
    vec("br_e_rs", 1, 0, 0, 0);

    // MULT in E with MFHI in D: start cycle + 4 busy cycles stalled
    clr(); hif.mdstartE = 1; hif.mfhiloD = 1;
    vec("mul_start", 1, 0, 0, 0);
    hif.mdstartE = 0;
    vec("mul_b1", 1, 1, 0, 0);
    vec("mul_b2", 1, 1, 0, 0);
    vec("mul_b3", 1, 1, 0, 0);
    vec("mul_b4", 1, 1, 1, 0);
    vec("mul_release", 0, 0, 0, 0);

    // DIV in E with MULT held in D; second start forced at busy cycle 10
    clr(); hif.mdstartE = 1; hif.mddivE = 1; hif.mdstartD = 1;
    vec("div_start", 1, 0, 0, 0);
    hif.mddivE = 0;
    for (int i = 1; i <= 32; i++) begin
      hif.mdstartE = (i == 10);
      vec($sformatf("div_b%0d", i), 1, 1, (i == 32), (i > 10));
    end
    hif.mdstartE = 0;
    vec("div_release", 0, 0, 0, 1);

    // Reset at DIV busy cycle 10
    clr(); hif.mdstartE = 1; hif.mddivE = 1;
    vec("div2_start", 0, 0, 0, 1);
    clr();
    for (int i = 1; i <= 9; i++) begin
      vec($sformatf("div2_b%0d", i), 0, 1, 0, 1);
    end
    reset_n = 1'b0;
    vec("rst_mid", 0, 0, 0, 0);
    vec("rst_hold", 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec($sformatf("post_rst%0d", i), 0, 0, 0, 0);
    end

    // Seven load-use cycles, then the counter is read in a quiet cycle
    clr(); hif.memtoregE = 1; hif.writeregE = 5'd8; hif.rsD = 5'd8;
    for (int i = 0; i < 7; i++) begin
      vec($sformatf("perf_lw%0d", i), 1, 0, 0, 0);
    end
    clr();
    vec("perf_chk", 0, 0, 0, 0);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline interlock controller for the 5-stage MIPS core; the stall/flush counterpart to the forwarding logic. It resolves every hazard that bypass muxes cannot: load-use, branch-compare-in-Decode, and multi-cycle MULT/DIV occupancy of HI/LO. It drives the Fetch/Decode enables and the Execute bubble, and owns the multiply/divide busy sequencer.

## Interface
Parameters:
- MUL_LAT, 4, cycles a MULT/MULTU occupies the HI/LO unit (≥1)
- DIV_LAT, 32, cycles a DIV/DIVU occupies the HI/LO unit (≥1)
- CNT_W, 6, busy-counter width; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- rsD, rtD  in  5  source registers of the instruction in Decode
- branchD  in  1  Decode holds BEQ/BNE (compare happens in D)
- mfhiloD  in  1  Decode holds MFHI/MFLO
- mdstartD  in  1  Decode holds MULT/DIV (any variant)
- writeregE, writeregM  in  5  destination register in E / M
- regwriteE  in  1  E instruction writes the register file
- memtoregE, memtoregM  in  1  E / M instruction is a load
- mdstartE  in  1  E holds a MULT/DIV launching this cycle
- mddivE  in  1  that E op is a divide (selects DIV_LAT)
- stallF, stallD  out  1  hold PC / hold IF-ID register
- flushE  out  1  clear ID-EX register (insert bubble)
- mdbusy  out  1  sequencer in BUSY
- mddone  out  1  last busy cycle; HI/LO written at its closing edge
- mderr  out  1  sticky: start received while BUSY
- stallcnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Register 0 never creates a hazard: every comparison requires the destination ≠ 0.
- lwstall = memtoregE & writeregE≠0 & (writeregE==rsD | writeregE==rtD).
- branchstall = branchD & [(regwriteE & writeregE≠0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM≠0 & writeregM∈{rsD,rtD})].
- mdstall = (mfhiloD | mdstartD) & (state==BUSY | mdstartE).
- stallF = stallD = flushE = lwstall | branchstall | mdstall; purely combinational from inputs and state.
- Sequencer FSM, two states:
  - IDLE: mdstartE → load cnt = (mddivE ? DIV_LAT : MUL_LAT) − 1, go BUSY.
  - BUSY: cnt≠0 → cnt−1, stay; cnt==0 → mddone=1, go IDLE.
  - mdstartE in BUSY: ignored (no reload, no extension), mderr set and held until reset.
  - mdstartE in the mddone cycle is also a BUSY-state start: ignored, mderr set.
- mdbusy = (state==BUSY); mddone = BUSY & cnt==0.

## Timing
- Reset (reset_n low, async): state=IDLE, cnt=0, mderr=0, stallcnt=0; combinational stall outputs follow inputs (all 0 when inputs are 0); mdbusy=mddone=0.
- Stall outputs: zero-latency, same cycle as the hazard.
- MULT sampled at edge T0 in IDLE: BUSY for cycles T0..T0+MUL_LAT−1, mddone in the last one, IDLE at edge T0+MUL_LAT.
- MFHI in D stalls from the cycle mdstartE is seen through the mddone cycle; released the following cycle.
- reset_n asserted mid-BUSY: immediate IDLE, in-flight op abandoned, no mddone.

## Configuration
- HAZARD_PERF_CNT_EN defined: stallcnt is a 32-bit register incremented on every clk edge where stallD=1, saturating at 32'hFFFF_FFFF, cleared only by reset.
- Undefined: stallcnt tied to 32'd0, no counter flops.

## Test plan
- Load-use: memtoregE=1, writeregE=8, rsD=8 → stallF=stallD=flushE=1 same cycle; writeregE=0, rsD=0 → all 0.
- Branch: branchD=1, rtD=9, regwriteE=1, writeregE=9 → stall; next cycle memtoregM=1, writeregM=9 → stall; regwriteE with writeregE=10 → no stall.
- MULT then MFHI: mdstartE=1, mddivE=0 with mfhiloD=1 → stall 5 cycles (start cycle + 4 BUSY), mddone in 4th BUSY cycle, stall drops next cycle.
- DIV then MULT in D: mddivE=1 → mdbusy 32 cycles, mdstartD held stalled throughout; second mdstartE forced mid-BUSY → mderr=1, busy length unchanged.
- Reset mid-DIV: reset_n low at BUSY cycle 10 → mdbusy=0 immediately, no mddone, mderr=0.
- Perf counter (macro on): 7 lwstall cycles → stallcnt=7; macro off → stallcnt stays 0.
